// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_unit
// Description : Multi-cycle RISC-V style control unit. A Moore FSM sequences
//               fetch/decode/execute/writeback. It produces datapath selects,
//               write strobes and the ALU operation code. It also counts
//               retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_unit #(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct75,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALU_control,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] C_OP_LW  = 7'b0000011;
    localparam logic [6:0] C_OP_SW  = 7'b0100011;
    localparam logic [6:0] C_OP_R   = 7'b0110011;
    localparam logic [6:0] C_OP_I   = 7'b0010011;
    localparam logic [6:0] C_OP_BEQ = 7'b1100011;
    localparam logic [6:0] C_OP_JAL = 7'b1101111;

    localparam logic [1:0] C_ALUOP_ADD  = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB  = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNC = 2'b10;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               w_retire;
    logic [1:0]         w_alu_op;

    // Next-state selection; memory-facing states wait on mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    C_OP_LW, C_OP_SW: state_d = S_MEMADR;
                    C_OP_R:           state_d = S_EXECUTER;
                    C_OP_I:           state_d = S_EXECUTEI;
                    C_OP_BEQ:         state_d = S_BEQ;
                    C_OP_JAL:         state_d = S_JAL;
                    default:          state_d = S_ILLEGAL;
                endcase
            end
            // opcode[5] distinguishes sw (1) from lw (0)
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
            S_ILLEGAL:  if (HALT_ON_ILLEGAL == 1'b0) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its final state
    always_comb begin
        w_retire = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_BEQ: w_retire = 1'b1;
            S_MEMWRITE:              w_retire = mem_ready;
            default:                 w_retire = 1'b0;
        endcase
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, w_retire};
    end

    // State and retired-instruction counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Moore output decode; write strobes are held low while in reset
    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        illegal   = 1'b0;
        w_alu_op  = C_ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                PCWrite   = mem_ready;
                IRWrite   = mem_ready;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA  = 2'b10;
                w_alu_op = C_ALUOP_FUNC;
            end
            S_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = C_ALUOP_FUNC;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = C_ALUOP_SUB;
                PCWrite  = zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
        if (!rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    // ALU operation; only R-type (opcode[5]=1) may select subtract via funct7
    always_comb begin
        ALU_control = C_ALU_ADD;
        case (w_alu_op)
            C_ALUOP_SUB: ALU_control = C_ALU_SUB;
            C_ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  ALU_control = (opcode[5] & funct75) ? C_ALU_SUB : C_ALU_ADD;
                    3'b010:  ALU_control = C_ALU_SLT;
                    3'b110:  ALU_control = C_ALU_OR;
                    3'b111:  ALU_control = C_ALU_AND;
                    default: ALU_control = C_ALU_ADD;
                endcase
            end
            default: ALU_control = C_ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        case (opcode)
            C_OP_LW, C_OP_I: ImmSrc = 2'b00;
            C_OP_SW:         ImmSrc = 2'b01;
            C_OP_BEQ:        ImmSrc = 2'b10;
            C_OP_JAL:        ImmSrc = 2'b11;
            default:         ImmSrc = 2'b00;
        endcase
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_unit
// Description : Randomized self-checking bench for mc_control_unit. It uses
//               an instruction-level reference model (state path, output
//               table, retirement count).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

    localparam int CNT_W = 8;

    localparam int ST_FETCH    = 0;
    localparam int ST_DECODE   = 1;
    localparam int ST_MEMADR   = 2;
    localparam int ST_MEMREAD  = 3;
    localparam int ST_MEMWB    = 4;
    localparam int ST_MEMWRITE = 5;
    localparam int ST_EXECR    = 6;
    localparam int ST_EXECI    = 7;
    localparam int ST_ALUWB    = 8;
    localparam int ST_BEQ      = 9;
    localparam int ST_JAL      = 10;
    localparam int ST_ILLEGAL  = 11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b0;
    logic [6:0]       opcode = 7'd0;
    logic [2:0]       funct3 = 3'd0;
    logic             funct75 = 1'b0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
    logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]       ALU_control;
    logic             illegal;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;

    mc_control_unit #(.CNT_W(CNT_W), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct75(funct75),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALU_control(ALU_control),
        .illegal(illegal), .instret(instret), .state(state)
    );

    int n_total = 0;
    int n_pass  = 0;
    int exp_instret = 0;

    logic [6:0] legal_ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

    // Arithmetic operation an R/I instruction asks for
    function automatic logic [2:0] arith_op(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        case (f3)
            3'b000:  return (op == OP_R && f75) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected output vector {PCW,IRW,MW,RW,Adr,Res,SrcA,SrcB,Imm,ALU,ill} per state
    function automatic logic [16:0] exp_outputs(input int st, input logic mr, input logic z,
                                                input logic [6:0] op, input logic [2:0] f3, input logic f75);
        logic pcw, irw, mw, rw, adr, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        pcw = 0; irw = 0; mw = 0; rw = 0; adr = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; alu = 3'b000;
        if (op == OP_SW) imm = 2'b01;
        else if (op == OP_BEQ) imm = 2'b10;
        else if (op == OP_JAL) imm = 2'b11;
        else imm = 2'b00;
        case (st)
            ST_FETCH:    begin pcw = mr; irw = mr; sb = 2'b10; rs = 2'b10; end
            ST_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            ST_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            ST_MEMREAD:  adr = 1;
            ST_MEMWB:    begin rs = 2'b01; rw = 1; end
            ST_MEMWRITE: begin adr = 1; mw = 1; end
            ST_EXECR:    begin sa = 2'b10; alu = arith_op(op, f3, f75); end
            ST_EXECI:    begin sa = 2'b10; sb = 2'b01; alu = arith_op(op, f3, f75); end
            ST_ALUWB:    rw = 1;
            ST_BEQ:      begin sa = 2'b10; alu = 3'b001; pcw = z; end
            ST_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            ST_ILLEGAL:  ill = 1;
            default: ;
        endcase
        return {pcw, irw, mw, rw, adr, rs, sa, sb, imm, alu, ill};
    endfunction

    // Zero-wait cycle count of each instruction class
    function automatic int base_len(input logic [6:0] op);
        if (op == OP_LW) return 5;
        if (op == OP_BEQ) return 3;
        return 4;
    endfunction

    // Drives one full instruction and checks every cycle against the model
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic z,
                             input int fetch_wait, input int mem_wait,
                             output int obs_len, output int rw_cycles, output int mw_cycles);
        int   path[$];
        logic rdy[$];
        int   prev_st;
        bit   done;
        logic [16:0] e, o;
        for (int i = 0; i < fetch_wait; i++) begin path.push_back(ST_FETCH); rdy.push_back(1'b0); end
        path.push_back(ST_FETCH);  rdy.push_back(1'b1);
        path.push_back(ST_DECODE); rdy.push_back($urandom_range(0, 1) != 0);
        if (op == OP_LW) begin
            path.push_back(ST_MEMADR); rdy.push_back($urandom_range(0, 1) != 0);
            for (int i = 0; i < mem_wait; i++) begin path.push_back(ST_MEMREAD); rdy.push_back(1'b0); end
            path.push_back(ST_MEMREAD); rdy.push_back(1'b1);
            path.push_back(ST_MEMWB);   rdy.push_back($urandom_range(0, 1) != 0);
        end else if (op == OP_SW) begin
            path.push_back(ST_MEMADR); rdy.push_back($urandom_range(0, 1) != 0);
            for (int i = 0; i < mem_wait; i++) begin path.push_back(ST_MEMWRITE); rdy.push_back(1'b0); end
            path.push_back(ST_MEMWRITE); rdy.push_back(1'b1);
        end else if (op == OP_BEQ) begin
            path.push_back(ST_BEQ); rdy.push_back($urandom_range(0, 1) != 0);
        end else begin
            path.push_back(op == OP_R ? ST_EXECR : (op == OP_I ? ST_EXECI : ST_JAL));
            rdy.push_back($urandom_range(0, 1) != 0);
            path.push_back(ST_ALUWB); rdy.push_back($urandom_range(0, 1) != 0);
        end
        obs_len = 0; rw_cycles = 0; mw_cycles = 0; done = 0; prev_st = ST_FETCH;
        foreach (path[i]) begin
            @(negedge clk);
            opcode = op; funct3 = f3; funct75 = f75; mem_ready = rdy[i];
            zero = (path[i] == ST_BEQ) ? z : ($urandom_range(0, 1) != 0);
            #1;
            n_total++;
            if (state !== 4'(path[i])) $display("FAIL state op=%b step=%0d: got %0d expected %0d", op, i, state, path[i]);
            else n_pass++;
            e = exp_outputs(path[i], rdy[i], zero, op, f3, f75);
            o = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU_control, illegal};
            n_total++;
            if (o !== e) $display("FAIL outputs op=%b f3=%b st=%0d: got %b expected %b", op, f3, path[i], o, e);
            else n_pass++;
            n_total++;
            if (instret !== CNT_W'(exp_instret)) $display("FAIL instret in-flight: got %0d expected %0d", instret, exp_instret);
            else n_pass++;
            if (i > 0 && state == 4'd0 && prev_st != ST_FETCH) done = 1;
            if (!done) obs_len++;
            prev_st = int'(state);
            rw_cycles += int'(RegWrite);
            mw_cycles += int'(MemWrite);
        end
        exp_instret = (exp_instret + 1) % (1 << CNT_W);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_total++;
        if (state !== 4'd0) $display("FAIL return_to_fetch op=%b: got %0d expected 0", op, state);
        else n_pass++;
        n_total++;
        if (instret !== CNT_W'(exp_instret)) $display("FAIL instret retire op=%b: got %0d expected %0d", op, instret, exp_instret);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = OP_R;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_total++;
            if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000)
                $display("FAIL reset_strobes: got %b expected 0000", {PCWrite, IRWrite, MemWrite, RegWrite});
            else n_pass++;
        end
        @(negedge clk); rst = 1'b1; mem_ready = 1'b0; #1;
        n_total++;
        if ({state, illegal, instret} !== {4'd0, 1'b0, CNT_W'(0)})
            $display("FAIL reset_release: got state=%0d illegal=%b instret=%0d expected 0/0/0", state, illegal, instret);
        else n_pass++;
        exp_instret = 0;
    endtask

    task automatic test_add();
        int len, rw, mw;
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, len, rw, mw);
        n_total++;
        if (len !== 4) $display("FAIL add_latency: got %0d expected 4", len); else n_pass++;
        n_total++;
        if (rw !== 1) $display("FAIL add_regwrite_cycles: got %0d expected 1", rw); else n_pass++;
    endtask

    task automatic test_sub_slti();
        int len, rw, mw;
        run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0, len, rw, mw);
        run_instr(OP_I, 3'b010, 1'b1, 1'b0, 0, 0, len, rw, mw);
        run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0, len, rw, mw);
        n_total++;
        if (len !== 4) $display("FAIL addi_latency: got %0d expected 4", len); else n_pass++;
    endtask

    task automatic test_sw_wait();
        int len, rw, mw;
        run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 3, len, rw, mw);
        n_total++;
        if (mw !== 4) $display("FAIL sw_memwrite_cycles: got %0d expected 4", mw); else n_pass++;
        n_total++;
        if (len !== 7) $display("FAIL sw_wait_latency: got %0d expected 7", len); else n_pass++;
    endtask

    task automatic test_beq();
        int len, rw, mw, start;
        start = exp_instret;
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, len, rw, mw);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, len, rw, mw);
        n_total++;
        if (instret !== CNT_W'(start + 2)) $display("FAIL beq_retire_pair: got %0d expected %0d", instret, start + 2);
        else n_pass++;
        n_total++;
        if (len !== 3) $display("FAIL beq_latency: got %0d expected 3", len); else n_pass++;
    endtask

    task automatic test_latency();
        int len, rw, mw, fw, mwt, exp_len;
        foreach (legal_ops[k]) begin
            fw = $urandom_range(0, 2); mwt = $urandom_range(0, 3);
            run_instr(legal_ops[k], 3'($urandom), 1'($urandom), 1'($urandom), fw, mwt, len, rw, mw);
            exp_len = base_len(legal_ops[k]) + fw + ((legal_ops[k] == OP_LW || legal_ops[k] == OP_SW) ? mwt : 0);
            n_total++;
            if (len !== exp_len) $display("FAIL latency op=%b: got %0d expected %0d", legal_ops[k], len, exp_len);
            else n_pass++;
        end
    endtask

    task automatic test_random(input int n);
        int len, rw, mw, fw, mwt, exp_len;
        logic [6:0] op;
        for (int k = 0; k < n; k++) begin
            op = legal_ops[$urandom_range(0, 5)];
            fw = $urandom_range(0, 1) * $urandom_range(0, 3);
            mwt = $urandom_range(0, 1) * $urandom_range(0, 3);
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), fw, mwt, len, rw, mw);
            exp_len = base_len(op) + fw + ((op == OP_LW || op == OP_SW) ? mwt : 0);
            n_total++;
            if (len !== exp_len) $display("FAIL random_latency op=%b: got %0d expected %0d", op, len, exp_len);
            else n_pass++;
        end
    endtask

    task automatic test_illegal();
        logic [6:0] op;
        bit is_legal;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) op = 7'b1111111;
            else begin
                do begin
                    op = 7'($urandom);
                    is_legal = 0;
                    foreach (legal_ops[k]) if (legal_ops[k] == op) is_legal = 1;
                end while (is_legal);
            end
            @(negedge clk); opcode = op; mem_ready = 1'b1; #1;
            n_total++;
            if (state !== 4'd0) $display("FAIL illegal_fetch: got %0d expected 0", state); else n_pass++;
            @(negedge clk); mem_ready = 1'b0; #1;
            n_total++;
            if (state !== 4'd1) $display("FAIL illegal_decode: got %0d expected 1", state); else n_pass++;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk); mem_ready = 1'($urandom); zero = 1'($urandom); #1;
                n_total++;
                if ({state, illegal, instret} !== {4'd11, 1'b1, CNT_W'(exp_instret)})
                    $display("FAIL illegal_halt c=%0d: got state=%0d illegal=%b instret=%0d expected 11/1/%0d",
                             c, state, illegal, instret, exp_instret);
                else n_pass++;
            end
            @(negedge clk); rst = 1'b0; #1;
            n_total++;
            if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000)
                $display("FAIL illegal_reset_strobes: got %b expected 0000", {PCWrite, IRWrite, MemWrite, RegWrite});
            else n_pass++;
            @(negedge clk); rst = 1'b1; mem_ready = 1'b0; #1;
            n_total++;
            if ({state, illegal, instret} !== {4'd0, 1'b0, CNT_W'(0)})
                $display("FAIL illegal_reset_release: got state=%0d illegal=%b instret=%0d expected 0/0/0",
                         state, illegal, instret);
            else n_pass++;
            exp_instret = 0;
        end
    endtask

    task automatic test_wrap();
        int len, rw, mw;
        while (exp_instret != (1 << CNT_W) - 1)
            run_instr(legal_ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom), 1'($urandom),
                      0, $urandom_range(0, 1), len, rw, mw);
        run_instr(OP_R, 3'b111, 1'b0, 1'b0, 0, 0, len, rw, mw);
        n_total++;
        if (instret !== CNT_W'(0)) $display("FAIL instret_wrap: got %0d expected 0", instret); else n_pass++;
    endtask

    task automatic test_reset_mid(input logic [6:0] op);
        int len, rw, mw;
        logic [3:0] wait_st;
        wait_st = (op == OP_LW) ? 4'd3 : 4'd5;
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, len, rw, mw);
        @(negedge clk); opcode = op; funct3 = 3'b010; mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        @(negedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            n_total++;
            if (state !== wait_st) $display("FAIL reset_mid_wait op=%b: got %0d expected %0d", op, state, wait_st);
            else n_pass++;
        end
        @(negedge clk); rst = 1'b0; mem_ready = 1'b1; zero = 1'b1; #1;
        n_total++;
        if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000)
            $display("FAIL reset_mid_strobes op=%b: got %b expected 0000", op, {PCWrite, IRWrite, MemWrite, RegWrite});
        else n_pass++;
        @(negedge clk); rst = 1'b1; mem_ready = 1'b0; #1;
        n_total++;
        if ({state, illegal, instret} !== {4'd0, 1'b0, CNT_W'(0)})
            $display("FAIL reset_mid_release op=%b: got state=%0d illegal=%b instret=%0d expected 0/0/0",
                     op, state, illegal, instret);
        else n_pass++;
        exp_instret = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_slti();
        test_sw_wait();
        test_beq();
        test_latency();
        test_random(150);
        test_illegal();
        test_wrap();
        test_reset_mid(OP_LW);
        test_reset_mid(OP_SW);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter (range 8..64).
REQ-002 SHALL have parameter HALT_ON_ILLEGAL, default 1: 1 = halt on illegal opcode; 0 = flag it and refetch.
REQ-003 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 opcode  in  7  instruction[6:0]; funct3  in  3  instruction[14:12]; funct75  in  1  instruction[30].
REQ-006 zero  in  1  ALU zero flag; mem_ready  in  1  unified memory access complete this cycle.
REQ-007 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each  write strobes / address select.
REQ-008 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each; ALU_control  out  3.
REQ-009 illegal  out  1  illegal-opcode flag; instret  out  CNT_W  retired count; state  out  4  debug state code.

Function
REQ-010 SHALL implement a Moore FSM. Codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=11.
REQ-011 Transitions:
- FETCH->DECODE only when mem_ready=1, else stay.
- DECODE by opcode: 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1100011->BEQ; 1101111->JAL; any other->ILLEGAL.
- MEMADR->MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD->MEMWB when mem_ready=1, else stay.
- MEMWRITE->FETCH when mem_ready=1, else stay.
- EXECUTER/EXECUTEI/JAL->ALUWB.
- MEMWB/ALUWB/BEQ->FETCH.
- ILLEGAL: stays until reset if HALT_ON_ILLEGAL=1, else ->FETCH.
REQ-012 Per-state outputs; all unlisted outputs are 0.
- FETCH: IRWrite=PCWrite=mem_ready, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until mem_ready.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, PCWrite=zero.
- JAL: ALUSrcA=01, ALUSrcB=10, PCWrite=1.
- ILLEGAL: illegal=1.
REQ-013 ImmSrc SHALL be combinational from opcode in every state: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, otherwise 00.
REQ-014 ALU_control encoding: add=000, sub=001, and=010, or=011, slt=101.
- ALUOp=00->add; ALUOp=01->sub.
- ALUOp=10 decodes funct3: 000->sub if opcode[5]&funct75, else add; 010->slt; 110->or; 111->and; other->add.
REQ-015 PCWrite and IRWrite are the only outputs SHALL depend combinationally on inputs (mem_ready, zero); all others depend on state and opcode/funct only.
REQ-016 instret SHALL increment by 1 on each edge leaving MEMWB, ALUWB or BEQ, or leaving MEMWRITE with mem_ready=1.
- Wraps from all-ones to 0.
- Never increments on the ILLEGAL path.
REQ-017 Latency: R/I-type 4 cycles, lw 5, sw 4, beq 3, jal 4, each with zero wait. Each mem_ready=0 cycle adds exactly one cycle.
REQ-018 illegal SHALL be asserted only in ILLEGAL. With HALT_ON_ILLEGAL=0 it is a one-cycle pulse.

Reset
REQ-019 On a rising edge with rst=0: state<=FETCH, instret<=0. Applies from any state, including mid-MEMWRITE wait and ILLEGAL halt.
REQ-020 While rst=0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0 regardless of state or inputs.
REQ-021 First cycle after rst returns to 1: state=FETCH, illegal=0, instret=0.

Verification
REQ-022 add (opcode 0110011, funct3 000, funct75 0), mem_ready=1 -> states 0,1,6,8,0. ALU_control=000 in EXECUTER. RegWrite=1 for exactly one cycle. instret 0->1.
REQ-023 sub then slti (0010011/010, funct75=1) -> sub gives ALU_control=001. slti gives 101, not sub.
REQ-024 sw, mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles. instret increments once, on the mem_ready=1 edge.
REQ-025 beq with zero=1, then beq with zero=0 -> PCWrite=1 in BEQ only for the first. Both retire; instret +2.
REQ-026 opcode 1111111, HALT_ON_ILLEGAL=1 -> state=11 and illegal=1 held 20 cycles, instret frozen. rst=0 one edge -> state=0.
REQ-027 CNT_W=8, preload via 255 retirements -> the 256th retirement wraps instret to 0. Assert rst=0 mid-MEMREAD -> all strobes 0, then FETCH.
